// File: rtl/oka_seq_mult.sv
// Sequential odd-even Karatsuba carry-less multiplier over GF(2)[x].
// One half-width core is time-shared across three cycles; squaring takes a one-cycle bypass.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// S0    | p0 <= ae*be
// S1    | p1 <= ao*bo
// S2    | middle term, recombine, load y
// DONE  | y valid, holding until out_ready
module oka_seq_mult #(
    parameter int N = 104
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sq,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);

    localparam int H = N / 2;

    if ((N % 2) != 0 || N < 4) begin : g_bad_n
        $error("oka_seq_mult: N must be even and >= 4");
    end

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S0   = 3'd1;
    localparam logic [2:0] S1   = 3'd2;
    localparam logic [2:0] S2   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]     state;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-2:0]   p0;
    logic [N-2:0]   p1;

    logic [H-1:0]   ae, ao, be, bo;
    logic [H-1:0]   ca, cb;
    logic [N-2:0]   core_p;
    logic [N-2:0]   m;
    logic [N-1:0]   p0_pad;
    logic [N-1:0]   p1_sh;
    logic [2*N-2:0] y_mul;
    logic [2*N-2:0] y_sq;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        ae = '0;
        ao = '0;
        be = '0;
        bo = '0;
        for (int k = 0; k < H; k++) begin
            ae[k] = a_r[2*k];
            ao[k] = a_r[2*k+1];
            be[k] = b_r[2*k];
            bo[k] = b_r[2*k+1];
        end
    end

    // S2 (and any unused encoding) feeds the Karatsuba middle-term operands.
    always_comb begin
        case (state)
            S0: begin
                ca = ae;
                cb = be;
            end
            S1: begin
                ca = ao;
                cb = bo;
            end
            default: begin
                ca = ae ^ ao;
                cb = be ^ bo;
            end
        endcase
    end

    always_comb begin
        core_p = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                core_p[i+j] = core_p[i+j] ^ (ca[i] & cb[j]);
            end
        end
    end

    assign m      = core_p ^ p0 ^ p1;
    assign p0_pad = {1'b0, p0};
    assign p1_sh  = {p1, 1'b0};

    always_comb begin
        y_mul = '0;
        for (int k = 0; k < N; k++) begin
            y_mul[2*k] = p0_pad[k] ^ p1_sh[k];
        end
        for (int k = 0; k < N - 1; k++) begin
            y_mul[2*k+1] = m[k];
        end
    end

    // Squaring over GF(2) only spreads the coefficients onto even powers.
    always_comb begin
        y_sq = '0;
        for (int i = 0; i < N; i++) begin
            y_sq[2*i] = a[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            p0        <= '0;
            p1        <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        if (sq) begin
                            y         <= y_sq;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= S0;
                        end
                    end
                end
                S0: begin
                    p0    <= core_p;
                    state <= S1;
                end
                S1: begin
                    p1    <= core_p;
                    state <= S2;
                end
                S2: begin
                    y         <= y_mul;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/oka_seq_mult.md
Name: oka_seq_mult

Overview:
- Parametrised, sequential successor to the fixed-width odd-even Karatsuba (OKA) GF(2) polynomial multiplier.
- Computes the carry-less product y = a·b over GF(2)[x] for N-bit operands. Uses one shared half-width (N/2) carry-less core three times, not three parallel cores.
- Adds a valid/ready handshake, result holding under backpressure, and a one-cycle squaring bypass.
- Sits between the operand-staging logic and the reduction stage of the field-arithmetic datapath.

Parameters:
- N, 104: operand width in bits. Must be even and ≥ 4. An odd or smaller value is an elaboration error.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operands a, b and sq are valid this cycle.
- in_ready  output  1  Block can accept operands. High only in IDLE.
- a  input  N  Operand polynomial, bit i = coefficient of x^i.
- b  input  N  Operand polynomial. Ignored when sq=1.
- sq  input  1  Squaring mode: y = a². Sampled with the operands.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  Consumer accepts y this cycle.
- y  output  2N-1  Product polynomial, registered.
- busy  output  1  High in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, y=0, internal p0/p1 registers=0, busy=0, in_ready=1 (in_ready decodes from state).
- Operand split, with h=N/2:
  - ae[k]=a[2k], ao[k]=a[2k+1]; be, bo likewise, for k=0..h-1.
  - Core: a single combinational h×h carry-less multiplier with an (N-1)-bit result, time-shared through a 3-way operand mux.
- FSM states: IDLE, S0, S1, S2, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a, b, sq into operand registers.
  - sq=0 → next state S0.
  - sq=1 → load y[2i]=a[i], y[2i+1]=0, set out_valid=1, next state DONE. Latency 1 edge.
- S0: p0 <= core(ae,be). Next S1.
- S1: p1 <= core(ao,bo). Next S2.
- S2: t = core(ae^ao, be^bo); m = t^p0^p1. Load y, set out_valid=1, next DONE.
  - y[2k] = p0[k] ^ p1[k-1], with p1[-1]=0 and p0[N-1]=0. Covers even bits 0..2N-2.
  - y[2k+1] = m[k]. Covers odd bits 1..2N-3.
- Latency (sq=0): out_valid rises 4 edges after the accepting edge. Throughput: one operation per ≥5 cycles.
- DONE:
  - y and out_valid are held stable while out_ready=0, for any number of cycles.
  - On out_ready=1: out_valid <= 0, next IDLE. y keeps its last value.
- Overlap and stray inputs:
  - in_valid is ignored outside IDLE. There is no overlap of operations; upstream must hold operands until in_ready.
  - out_ready outside DONE has no effect.
- rst mid-operation, in any state: abandon the operation. Next cycle state=IDLE, out_valid=0, y=0. No partial result is ever presented.
- Arithmetic is pure XOR/AND; there are no carries.
- Result MSB y[2N-2] = a[N-1]&b[N-1].

Test Plan:
- N=8, a=0x03, b=0x03, sq=0 → y=0x0005 exactly 4 edges after the accept edge. in_ready=0 and busy=1 throughout.
- N=8, a=0xFF, b=0xFF → y=0x5555. Then a=0x80, b=0x80 → y=0x4000, i.e. MSB y[14] set and all other bits 0.
- N=8, sq=1, a=0x0B, b=0xFF → y=0x0045 one edge after accept. b has no effect.
- N=8, a=0x03, b=0x05 → y=0x0F (x³+x²+x+1). Hold out_ready=0 for 6 cycles: y stable, out_valid=1, in_ready=0, and in_valid pulses are ignored. Raise out_ready → IDLE next cycle.
- N=8: assert rst in S1 → next cycle out_valid=0, y=0, in_ready=1. A subsequent a=0x03, b=0x03 yields 0x0005 with no stale data.
- Default N=104: 1000 random (a, b, sq) with random out_ready backpressure vs. a schoolbook carry-less reference model → bit-exact match. Also a=b=all-ones → y has all even bits set and all odd bits 0.
